// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, read owner tags,
// and the funct3 size/sign codes that ride on the strobe lines.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    YIELD = 2'd2
  } state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } owner_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of cycles port d has been refused; starved_o forces a d win.
module arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_req_i,
  input  logic d_gnt_i,
  output logic starved_o
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  logic [SW-1:0] cnt_q, cnt_d;

  assign starved_o = (cnt_q == SW'(MAX_WAIT));

  always_comb begin
    cnt_d = '0;
    if (d_req_i && !d_gnt_i)
      cnt_d = starved_o ? cnt_q : cnt_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMem: core priority, starve
// guard and bounded lock bursts for port d, tagged one-cycle-late read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [2:0]    c_strb,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [2:0]    d_strb,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_strb,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  state_e         state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           rd_pend_q, rd_pend_d;
  owner_e         owner_q, owner_d;
  logic           starved;

  arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .d_req_i   (d_req),
    .d_gnt_i   (d_gnt),
    .starved_o (starved)
  );

  always_comb begin
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (rst) begin
      unique case (state_q)
        ARB: begin
          if (d_req && starved) d_gnt = 1'b1;
          else if (c_req)       c_gnt = 1'b1;
          else if (d_req)       d_gnt = 1'b1;
          if (d_gnt && d_lock) begin
            state_d    = LOCK;
            lock_cnt_d = LCW'(1);
          end
        end
        LOCK: begin
          // Core is held off for the whole lock, even on idle d cycles.
          d_gnt = d_req;
          if (d_gnt) lock_cnt_d = lock_cnt_q + LCW'(1);
          if (!d_lock)                                   state_d = ARB;
          else if (d_gnt && lock_cnt_d == LCW'(LOCK_MAX)) state_d = YIELD;
        end
        YIELD: begin
          if (c_req)      c_gnt = 1'b1;
          else if (d_req) d_gnt = 1'b1;
          state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign c_stall   = c_req & ~c_gnt;
  assign mem_addr  = d_gnt ? d_addr  : c_addr;
  assign mem_wdata = d_gnt ? d_wdata : c_wdata;
  assign mem_strb  = d_gnt ? d_strb  : c_strb;
  assign mem_we    = (c_gnt & c_we) | (d_gnt & d_we);

  assign rd_pend_d = (c_gnt & ~c_we) | (d_gnt & ~d_we);
  assign owner_d   = d_gnt ? PORT_D : PORT_C;

  // Gating with rst drops a read whose return cycle lands in reset.
  assign c_rvalid = rst & rd_pend_q & (owner_q == PORT_C);
  assign d_rvalid = rst & rd_pend_q & (owner_q == PORT_D);
  assign rdata    = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      owner_q    <= PORT_C;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      owner_q    <= owner_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants checked per cycle, read returns
// checked by a scoreboard monitor against a ROM-style memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic [2:0]  c_strb, d_strb;
  logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_strb;

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  dmem_arbiter #(.MAX_WAIT(4), .LOCK_MAX(8), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_strb(c_strb),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory word at byte address A reads as 0xA00000xx with xx = A[7:0].
  always @(posedge clk) mem_rdata <= 32'hA000_0000 | {24'h0, mem_addr[7:0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic p, input logic [31:0] d);
    sb.push_back('{port: p, data: d, cyc: cyc + 1});
  endtask

  task automatic step(input string nm, input logic ec, input logic ed);
    @(negedge clk);
    chk({nm, ".c_gnt"},   32'(c_gnt),   32'(ec));
    chk({nm, ".d_gnt"},   32'(d_gnt),   32'(ed));
    chk({nm, ".c_stall"}, 32'(c_stall), 32'(c_req & ~ec));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; d_req = 0; d_we = 0; d_lock = 0;
  endtask

  // Scoreboard monitor: every rvalid must match the queue head, in order and on time.
  always @(negedge clk) begin
    if (c_rvalid && d_rvalid) chk("rv_onehot", 32'(1), 32'(0));
    if (c_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        chk("rv_unexpected", {31'h0, d_rvalid}, 32'hFFFF_FFFF);
      end else begin
        chk("rv_port", 32'(d_rvalid), 32'(sb[0].port));
        chk("rv_data", rdata, sb[0].data);
        chk("rv_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      chk("rv_missing", 32'(0), 32'(1));
      void'(sb.pop_front());
    end
  end

  initial begin
    rst = 0; idle();
    c_addr = 0; d_addr = 0; c_wdata = 32'h1111_0000; d_wdata = 32'h2222_0000;
    c_strb = 3'b010; d_strb = 3'b010;
    @(posedge clk); #1;

    // Reset: grants forced low, no write strobe.
    c_req = 1; c_we = 1; d_req = 1; d_we = 1;
    @(negedge clk);
    chk("rst.mem_we", 32'(mem_we), 32'(0));
    chk("rst.c_rvalid", 32'(c_rvalid), 32'(0));
    step("rst", 0, 0);
    rst = 1; idle();

    // Core-only read of 0x40.
    c_req = 1; c_addr = 32'h40; push(1'b0, 32'hA000_0040);
    step("core_rd", 1, 0);
    idle(); step("core_rd_idle", 0, 0);

    // Contention: 4 core wins, then the starve guard gives d one grant.
    c_req = 1; c_we = 1; c_addr = 32'h80; d_req = 1; d_we = 1; d_addr = 32'h84;
    for (int i = 0; i < 4; i++) step("cont_core", 1, 0);
    step("cont_starve", 0, 1);
    step("cont_after", 1, 0);
    idle(); step("cont_idle", 0, 0);

    // Lock burst: starve win with lock, 8 d grants, YIELD to core, then ARB.
    c_req = 1; c_we = 1; d_req = 1; d_we = 1; d_lock = 1;
    for (int i = 0; i < 4; i++) step("burst_core", 1, 0);
    for (int i = 0; i < 8; i++) step("burst_d", 0, 1);
    step("burst_yield", 1, 0);
    step("burst_arb", 1, 0);
    idle(); step("burst_idle", 0, 0);

    // Lock release after 3 grants: held idle cycle, then ARB grants core.
    d_req = 1; d_we = 1; d_lock = 1;
    step("rel_d1", 0, 1);
    c_req = 1; c_we = 1;
    step("rel_d2", 0, 1);
    step("rel_d3", 0, 1);
    d_req = 0; d_lock = 0;
    step("rel_hold", 0, 0);
    step("rel_core", 1, 0);
    idle(); step("rel_idle", 0, 0);

    // Interleaved reads with a write in between.
    c_req = 1; c_we = 0; c_addr = 32'h10; push(1'b0, 32'hA000_0010);
    step("il_c_rd", 1, 0);
    c_req = 0; d_req = 1; d_we = 0; d_addr = 32'h20; push(1'b1, 32'hA000_0020);
    step("il_d_rd", 0, 1);
    d_req = 0; c_req = 1; c_we = 1; c_addr = 32'h88;
    step("il_c_wr", 1, 0);
    c_req = 0; d_req = 1; d_we = 0; d_addr = 32'h24; push(1'b1, 32'hA000_0024);
    step("il_d_rd2", 0, 1);
    idle(); step("il_idle", 0, 0);

    // Reset while locked with a read outstanding.
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 32'h20; push(1'b1, 32'hA000_0020);
    step("rl_enter", 0, 1);
    step("rl_pending", 0, 1);
    rst = 0; c_req = 1; c_we = 1;
    @(negedge clk);
    chk("rl_rst.mem_we", 32'(mem_we), 32'(0));
    step("rl_rst", 0, 0);
    rst = 1;
    step("rl_arb", 1, 0);
    idle(); step("rl_idle1", 0, 0);
    step("rl_idle2", 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core MEM stage (port c) and an external loader/DMA engine (port d). Sits between those requesters and DataMem.
- Per-cycle grant. Core has fixed priority, with a starvation guard for port d. Port d can lock the memory for a bounded burst.
- Routes the one-cycle-late read data back to whichever requester issued the read.

Parameters:
- MAX_WAIT, 4: cycles port d may be refused before it is forced to win.
- LOCK_MAX, 8: maximum consecutive granted port-d accesses under lock before a forced yield.
- AW, 32: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- c_req  in  1  core access request.
- c_we  in  1  core write enable.
- c_addr  in  AW  core byte address.
- c_wdata  in  32  core store data.
- c_strb  in  3  core funct3 size/sign code.
- c_gnt  out  1  core access accepted this cycle.
- c_stall  out  1  c_req & ~c_gnt; freezes the pipeline.
- c_rvalid  out  1  core read data valid.
- d_req, d_we, d_addr, d_wdata, d_strb  in  1/1/AW/32/3  same meanings as the core signals, for port d.
- d_lock  in  1  port d requests to hold the memory for its following accesses.
- d_gnt  out  1  port d access accepted.
- d_rvalid  out  1  port d read data valid.
- rdata  out  32  mem_rdata passed through; qualified by c_rvalid or d_rvalid.
- mem_addr, mem_wdata, mem_strb  out  AW/32/3  muxed from the winning port.
- mem_we  out  1  gated write enable; 0 when no port is granted.
- mem_rdata  in  32  DataMem read data, valid the cycle after the address is issued.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=ARB, starve_cnt=0, lock_cnt=0.
  - c_rvalid=0, d_rvalid=0.
  - Grants forced to 0 while rst=0.
  - Reset during a lock or with a read pending drops it; no rvalid follows.
- Grant logic:
  - Combinational from the request inputs and registered state.
  - At most one of c_gnt and d_gnt is high.
  - The memory mux selects the granted port; if neither is granted it selects port c with mem_we=0.
- State ARB:
  - Grant to d if d_req && starve_cnt==MAX_WAIT.
  - Else grant to c if c_req.
  - Else grant to d if d_req.
  - If d is granted and d_lock=1: go to LOCK, lock_cnt=1.
- State LOCK:
  - d has absolute priority. Grant to d if d_req; core stalls even when d_req=0 (idle cycle held).
  - On each d grant, lock_cnt increments.
  - If d_lock=0: go to ARB next cycle.
  - Else if lock_cnt==LOCK_MAX and a d grant occurs: go to YIELD.
- State YIELD (exactly one cycle):
  - Core priority; d is granted only if c_req=0.
  - Always returns to ARB, whatever d_lock is.
  - d_lock is ignored in this cycle, so a new lock cannot start from YIELD.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) when d_req && !d_gnt.
  - Clears when d_gnt=1 or d_req=0.
- Read return:
  - Register owner_q and rd_pend_q for any granted access with we=0.
  - Next cycle: c_rvalid or d_rvalid = 1 for that owner, with rdata = mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating ports are supported: each return is tagged independently, no bubble.
- Simultaneous events:
  - Both requesting in ARB with starve_cnt<MAX_WAIT: core wins.
  - d_lock rising in the same cycle that the starve rule grants d: lock is entered.
- Requesters must hold req, addr and data stable until they see gnt.

Decomposition:
- Shared package:
  - state encoding: ARB=2'd0, LOCK=2'd1, YIELD=2'd2.
  - funct3 strobe codes.
  - owner encoding: PORT_C=0, PORT_D=1.
- One natural sub-module, arb_starve_ctr: the saturating starve counter with its compare output.
- The lock FSM and the mux stay in the top level.

Test Plan:
- Core only: c_req with a read of address 0x40 at cycle N -> c_gnt=1 at N, c_rvalid=1 at N+1 with rdata=mem[0x40], d outputs stay 0.
- Contention: c_req and d_req both held high with MAX_WAIT=4 -> core granted for 4 cycles, d_gnt=1 on the 5th, starve_cnt then 0, c_stall=1 on that cycle.
- Lock burst: d_lock=1 with d_req high and c_req high -> 8 consecutive d_gnt, then 1 cycle c_gnt (YIELD), then state ARB.
- Lock release: d_lock drops after 3 grants -> ARB next cycle; core is granted the following cycle if c_req=1.
- Interleaved reads: c read of 0x10, then d read of 0x20 on consecutive cycles -> c_rvalid then d_rvalid on consecutive cycles, each with the correct data; a write between them produces no rvalid.
- Reset in LOCK with a read pending -> after reset, state=ARB, no rvalid pulse, mem_we=0.
